mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and access sequencer for the single-port unified memory of the multicycle core. It shares the one memory port between the core's fetch/load/store path and the program loader. It serialises accesses with round-robin fairness and drives the memory control signals with fixed-latency timing. Each requester sees a simple req/done handshake, regardless of which requester holds the port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 1, cycles from the `mem_en` cycle to `mem_rdata` being valid; legal range 1..16
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- core_req  in  1  core access request; held until `core_done`
- core_we  in  1  1 = write, 0 = read
- core_addr  in  ADDR_W  access address
- core_wdata  in  DATA_W  write data
- core_gnt  out  1  core owns the port; reset 0
- core_done  out  1  one-cycle completion pulse; reset 0
- core_rdata  out  DATA_W  registered read data; reset 0
- ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_gnt, ldr_done, ldr_rdata: loader copies of the core ports above, same widths and resets
- busy  out  1  state != IDLE; reset 0
- mem_en  out  1  memory access strobe, one cycle per access; reset 0
- mem_we  out  1  memory write enable, valid only with `mem_en`; reset 0
- mem_addr  out  ADDR_W  registered address; reset 0
- mem_wdata  out  DATA_W  registered write data; reset 0
- mem_rdata  in  DATA_W  memory read data; valid exactly MEM_LATENCY cycles after the `mem_en` cycle

## Operation
- States: IDLE, ACCESS, WAIT, CAPTURE, DONE.
- IDLE
  - Requests are sampled only in IDLE.
  - If no request is present, stay in IDLE.
  - If exactly one request is present, that requester wins.
  - If both are present, the winner is the requester not recorded in `last`.
  - On the edge: latch the winner id, we, addr and wdata into the `mem_*` registers; update `last` to the winner; go to ACCESS.
  - `last` resets to loader, so the core wins the first tie.
- ACCESS
  - `mem_en`=1 and `mem_we`=latched we.
  - Load the latency counter with MEM_LATENCY-1.
  - Go to CAPTURE if MEM_LATENCY=1, otherwise to WAIT.
- WAIT: decrement the counter; leave for CAPTURE when the counter reaches 1 on that edge. Total WAIT duration is MEM_LATENCY-1 cycles.
- CAPTURE: on a read, the winner's rdata register takes `mem_rdata` at the edge. Then go to DONE.
- DONE
  - The winner's done pulses for one cycle.
  - Return to IDLE.
- `*_gnt` is high for the winner from ACCESS through DONE inclusive.
- On a write, `*_rdata` holds its previous value. The loser's rdata is never modified.
- A request withdrawn after being granted does not abort the access: it completes and done still pulses.
- A request withdrawn before the IDLE sample is ignored.
- `mem_addr` and `mem_wdata` hold the last access values outside ACCESS.
- Reset mid-access:
  - State goes to IDLE and `last` goes to loader.
  - All outputs go to their reset values immediately (async).
  - The in-flight access is dropped and no done is issued.

## Timing
- Latency: request seen in IDLE at cycle 0 → ACCESS at cycle 1 → `mem_rdata` sampled at the end of cycle 1+MEM_LATENCY → done in cycle 2+MEM_LATENCY.
- Port occupancy per access is MEM_LATENCY+3 cycles including the IDLE sample cycle.
- Back-to-back: a requester still asserting req in the DONE cycle is treated as a new request at the next IDLE. Arbitration there alternates if both are requesting.
- Throughput with both requesting: strict alternation, core, ldr, core, …
- `mem_en` is never high on two consecutive cycles.

## Structure
- Shared include `arbiter_defs.v` (alongside the existing opcode defines) holds:
  - state encodings (3 bits)
  - requester id constants: CORE=0, LDR=1
  - the default MEM_LATENCY
- One natural sub-module: `rr_pick2`. It is a combinational two-way round-robin picker taking req[1:0] and `last`, and returning valid and winner id. `last` is kept in the parent.
- The latency counter and capture registers live in the top module.

## Test plan
- Single core read, MEM_LATENCY=1, memory model returns 0xDEADBEEF for addr 0x10 → `mem_en` high in cycle 1 only, `core_rdata`=0xDEADBEEF, `core_done` in cycle 3, `ldr_*` untouched.
- Both requesters assert from reset and stay asserted, MEM_LATENCY=3 → grants go core, ldr, core, ldr. Each done is 5 cycles after its ACCESS-preceding IDLE, and there is no overlapping `mem_en`.
- Loader write addr 0x40, data 0x12345678, then core read of 0x40 → the memory model sees `mem_we`=1 with the matching addr/data, and the core read returns 0x12345678. Before the write, `ldr_rdata` held its prior value.
- Core drops req one cycle after ACCESS → access completes and `core_done` still pulses once. Loader asserting req in the meantime is granted only after DONE.
- `rst` asserted during WAIT (MEM_LATENCY=4) → `busy`, `mem_en`, both gnt and both done are 0 asynchronously. After release, a tie is granted to the core.
- MEM_LATENCY=16 single read → `core_done` exactly 18 cycles after the IDLE sample cycle, with the counter not wrapping.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared states, requester ids and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCESS  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic ID_CORE = 1'b0;
    localparam logic ID_LDR  = 1'b1;

    localparam int DEFAULT_MEM_LATENCY = 1;
    // Wide enough for a load value of 15 (latency 16) without wrapping.
    localparam int CNT_W = 5;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// rtl/mem_port_arbiter_rr_pick2.sv - combinational two-way round-robin picker
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = ID_CORE;
        // On a tie the requester that did not win last time goes next.
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = ID_LDR;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between core and loader with fixed-latency sequencing
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_done,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_done,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   core_rdata_q, core_rdata_d;
    logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
    logic                pick_valid;
    logic                pick_winner;

    rr_pick2 u_pick (
        .req    ({ldr_req, core_req}),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        we_d         = we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cnt_d        = cnt_q;
        core_rdata_d = core_rdata_q;
        ldr_rdata_d  = ldr_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d     = pick_winner;
                    last_d      = pick_winner;
                    we_d        = (pick_winner == ID_LDR) ? ldr_we    : core_we;
                    mem_addr_d  = (pick_winner == ID_LDR) ? ldr_addr  : core_addr;
                    mem_wdata_d = (pick_winner == ID_LDR) ? ldr_wdata : core_wdata;
                    state_d     = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d   = CNT_W'(MEM_LATENCY - 1);
                state_d = (MEM_LATENCY == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                // Leaving on a count of 1 gives exactly MEM_LATENCY-1 wait cycles.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!we_q) begin
                    if (owner_q == ID_LDR) begin
                        ldr_rdata_d = mem_rdata;
                    end else begin
                        core_rdata_d = mem_rdata;
                    end
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_q       <= ID_LDR;
            owner_q      <= ID_CORE;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cnt_q        <= '0;
            core_rdata_q <= '0;
            ldr_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cnt_q        <= cnt_d;
            core_rdata_q <= core_rdata_d;
            ldr_rdata_q  <= ldr_rdata_d;
        end
    end

    // Outputs decode directly from state so an async reset clears them at once.
    assign busy       = (state_q != ST_IDLE);
    assign mem_en     = (state_q == ST_ACCESS);
    assign mem_we     = mem_en & we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign core_gnt   = busy & (owner_q == ID_CORE);
    assign ldr_gnt    = busy & (owner_q == ID_LDR);
    assign core_done  = (state_q == ST_DONE) & (owner_q == ID_CORE);
    assign ldr_done   = (state_q == ST_DONE) & (owner_q == ID_LDR);
    assign core_rdata = core_rdata_q;
    assign ldr_rdata  = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter at latencies 1, 3, 4 and 16
module tb_mem_port_arbiter;

    localparam int N = 4;
    localparam int LAT [N] = '{1, 3, 4, 16};

    logic        clk;
    logic        rst;
    logic        core_req   [N];
    logic        core_we    [N];
    logic [31:0] core_addr  [N];
    logic [31:0] core_wdata [N];
    logic        core_gnt   [N];
    logic        core_done  [N];
    logic [31:0] core_rdata [N];
    logic        ldr_req    [N];
    logic        ldr_we     [N];
    logic [31:0] ldr_addr   [N];
    logic [31:0] ldr_wdata  [N];
    logic        ldr_gnt    [N];
    logic        ldr_done   [N];
    logic [31:0] ldr_rdata  [N];
    logic        busy       [N];
    logic        mem_en     [N];
    logic        mem_we     [N];
    logic [31:0] mem_addr   [N];
    logic [31:0] mem_wdata  [N];
    logic [31:0] mem_rdata  [N];

    int en_cnt  [N];
    int dbl_cnt [N];
    int cd_cnt  [N];
    int ld_cnt  [N];
    int lg_cnt  [N];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | a);
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_port_arbiter #(
            .ADDR_W      (32),
            .DATA_W      (32),
            .MEM_LATENCY (LAT[g])
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .core_req   (core_req[g]),
            .core_we    (core_we[g]),
            .core_addr  (core_addr[g]),
            .core_wdata (core_wdata[g]),
            .core_gnt   (core_gnt[g]),
            .core_done  (core_done[g]),
            .core_rdata (core_rdata[g]),
            .ldr_req    (ldr_req[g]),
            .ldr_we     (ldr_we[g]),
            .ldr_addr   (ldr_addr[g]),
            .ldr_wdata  (ldr_wdata[g]),
            .ldr_gnt    (ldr_gnt[g]),
            .ldr_done   (ldr_done[g]),
            .ldr_rdata  (ldr_rdata[g]),
            .busy       (busy[g]),
            .mem_en     (mem_en[g]),
            .mem_we     (mem_we[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_rdata  (mem_rdata[g])
        );

        // Memory model: read data is presented only in the cycle exactly LAT after mem_en.
        logic [31:0]  wmem [256];
        logic [255:0] wvalid;
        logic [31:0]  pend;
        int           rcnt = 0;
        logic         prev_en = 1'b0;
        int           n_en = 0, n_dbl = 0, n_cd = 0, n_ld = 0, n_lg = 0;

        always @(posedge clk) begin
            if (rst) begin
                wvalid  <= '0;
                rcnt    <= 0;
                prev_en <= 1'b0;
            end else begin
                prev_en <= mem_en[g];
                if (mem_en[g]) begin
                    if (mem_we[g]) begin
                        wmem[mem_addr[g][7:0]]   <= mem_wdata[g];
                        wvalid[mem_addr[g][7:0]] <= 1'b1;
                    end else begin
                        pend <= wvalid[mem_addr[g][7:0]] ? wmem[mem_addr[g][7:0]] : pat(mem_addr[g]);
                    end
                    rcnt <= 1;
                end else if (rcnt != 0 && rcnt < 64) begin
                    rcnt <= rcnt + 1;
                end
            end
            if (mem_en[g])               n_en  <= n_en + 1;
            if (mem_en[g] && prev_en)    n_dbl <= n_dbl + 1;
            if (core_done[g])            n_cd  <= n_cd + 1;
            if (ldr_done[g])             n_ld  <= n_ld + 1;
            if (ldr_gnt[g])              n_lg  <= n_lg + 1;
        end

        assign mem_rdata[g] = (rcnt == LAT[g]) ? pend : 32'hBAD0BAD0;
        assign en_cnt[g]    = n_en;
        assign dbl_cnt[g]   = n_dbl;
        assign cd_cnt[g]    = n_cd;
        assign ld_cnt[g]    = n_ld;
        assign lg_cnt[g]    = n_lg;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int cd_before;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            core_req[i] = 1'b0; core_we[i] = 1'b0; core_addr[i] = '0; core_wdata[i] = '0;
            ldr_req[i]  = 1'b0; ldr_we[i]  = 1'b0; ldr_addr[i]  = '0; ldr_wdata[i]  = '0;
        end
        repeat (3) step();
        for (int i = 0; i < N; i++) begin
            chk("rst_busy", busy[i], 1'b0);
            chk("rst_mem_en", mem_en[i], 1'b0);
            chk("rst_core_gnt", core_gnt[i], 1'b0);
            chk("rst_ldr_gnt", ldr_gnt[i], 1'b0);
            chk("rst_core_done", core_done[i], 1'b0);
            chk("rst_mem_addr", mem_addr[i], 32'h0);
            chk("rst_core_rdata", core_rdata[i], 32'h0);
        end
        rst = 1'b0;
        step();

        // Single core read, latency 1
        core_req[0] = 1'b1; core_addr[0] = 32'h10;
        step();
        chk("t1_mem_en_c1", mem_en[0], 1'b1);
        chk("t1_core_gnt_c1", core_gnt[0], 1'b1);
        chk("t1_mem_addr", mem_addr[0], 32'h10);
        chk("t1_mem_we", mem_we[0], 1'b0);
        step();
        chk("t1_mem_en_c2", mem_en[0], 1'b0);
        chk("t1_done_c2", core_done[0], 1'b0);
        step();
        chk("t1_done_c3", core_done[0], 1'b1);
        chk("t1_rdata", core_rdata[0], 32'hDEADBEEF);
        core_req[0] = 1'b0;
        step();
        chk("t1_done_c4", core_done[0], 1'b0);
        chk("t1_busy_c4", busy[0], 1'b0);
        chk("t1_en_count", en_cnt[0], 1);
        chk("t1_ldr_rdata", ldr_rdata[0], 32'h0);
        chk("t1_ldr_gnt_count", lg_cnt[0], 0);
        chk("t1_ldr_done_count", ld_cnt[0], 0);

        // Both requesting, latency 3: strict alternation
        core_req[1] = 1'b1; core_addr[1] = 32'h20;
        ldr_req[1]  = 1'b1; ldr_addr[1]  = 32'h30;
        for (int k = 0; k < 4; k++) begin
            chk("t2_idle_busy", busy[1], 1'b0);
            step();
            chk("t2_core_gnt", core_gnt[1], (k % 2) == 0);
            chk("t2_ldr_gnt", ldr_gnt[1], (k % 2) == 1);
            chk("t2_mem_addr", mem_addr[1], ((k % 2) == 0) ? 32'h20 : 32'h30);
            repeat (4) step();
            if ((k % 2) == 0) begin
                chk("t2_core_done", core_done[1], 1'b1);
                chk("t2_core_rdata", core_rdata[1], 32'hC0DE0020);
            end else begin
                chk("t2_ldr_done", ldr_done[1], 1'b1);
                chk("t2_ldr_rdata", ldr_rdata[1], 32'hC0DE0030);
            end
            if (k == 3) begin
                core_req[1] = 1'b0;
                ldr_req[1]  = 1'b0;
            end
            step();
        end
        chk("t2_en_count", en_cnt[1], 4);
        chk("t2_double_en", dbl_cnt[1], 0);
        chk("t2_core_dones", cd_cnt[1], 2);
        chk("t2_ldr_dones", ld_cnt[1], 2);

        // Loader write then core read-back
        chk("t3_ldr_rdata_prior", ldr_rdata[1], 32'hC0DE0030);
        ldr_req[1] = 1'b1; ldr_we[1] = 1'b1; ldr_addr[1] = 32'h40; ldr_wdata[1] = 32'h12345678;
        step();
        chk("t3_mem_en", mem_en[1], 1'b1);
        chk("t3_mem_we", mem_we[1], 1'b1);
        chk("t3_mem_addr", mem_addr[1], 32'h40);
        chk("t3_mem_wdata", mem_wdata[1], 32'h12345678);
        ldr_req[1] = 1'b0;
        repeat (4) step();
        chk("t3_ldr_done", ldr_done[1], 1'b1);
        chk("t3_ldr_rdata_kept", ldr_rdata[1], 32'hC0DE0030);
        step();
        core_req[1] = 1'b1; core_we[1] = 1'b0; core_addr[1] = 32'h40;
        step();
        chk("t3_core_gnt", core_gnt[1], 1'b1);
        core_req[1] = 1'b0;
        repeat (4) step();
        chk("t3_core_done", core_done[1], 1'b1);
        chk("t3_core_rdata", core_rdata[1], 32'h12345678);
        step();

        // Core withdraws after grant; loader waits for DONE
        cd_before = cd_cnt[1];
        core_req[1] = 1'b1; core_addr[1] = 32'h50;
        step();
        chk("t4_core_gnt", core_gnt[1], 1'b1);
        step();
        core_req[1] = 1'b0;
        ldr_req[1] = 1'b1; ldr_we[1] = 1'b0; ldr_addr[1] = 32'h60;
        step();
        chk("t4_ldr_gnt_c3", ldr_gnt[1], 1'b0);
        repeat (2) step();
        chk("t4_core_done", core_done[1], 1'b1);
        chk("t4_ldr_gnt_c5", ldr_gnt[1], 1'b0);
        step();
        chk("t4_idle_ldr_gnt", ldr_gnt[1], 1'b0);
        chk("t4_idle_busy", busy[1], 1'b0);
        chk("t4_core_done_once", cd_cnt[1], cd_before + 1);
        step();
        chk("t4_ldr_gnt", ldr_gnt[1], 1'b1);
        ldr_req[1] = 1'b0;
        repeat (4) step();
        chk("t4_ldr_done", ldr_done[1], 1'b1);
        chk("t4_ldr_rdata", ldr_rdata[1], 32'hC0DE0060);
        step();

        // Reset during WAIT, latency 4
        core_req[2] = 1'b1; core_addr[2] = 32'h24;
        ldr_req[2]  = 1'b1; ldr_addr[2]  = 32'h34;
        step();
        chk("t5_first_core_gnt", core_gnt[2], 1'b1);
        repeat (2) step();
        chk("t5_in_wait_busy", busy[2], 1'b1);
        rst = 1'b1;
        #1;
        chk("t5_async_busy", busy[2], 1'b0);
        chk("t5_async_mem_en", mem_en[2], 1'b0);
        chk("t5_async_core_gnt", core_gnt[2], 1'b0);
        chk("t5_async_ldr_gnt", ldr_gnt[2], 1'b0);
        chk("t5_async_core_done", core_done[2], 1'b0);
        chk("t5_async_ldr_done", ldr_done[2], 1'b0);
        chk("t5_async_mem_addr", mem_addr[2], 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("t5_tie_core_gnt", core_gnt[2], 1'b1);
        chk("t5_tie_ldr_gnt", ldr_gnt[2], 1'b0);
        core_req[2] = 1'b0;
        ldr_req[2]  = 1'b0;
        repeat (5) step();
        chk("t5_core_done", core_done[2], 1'b1);
        chk("t5_core_rdata", core_rdata[2], 32'hC0DE0024);
        chk("t5_done_count", cd_cnt[2], 0);
        step();
        chk("t5_done_count_after", cd_cnt[2], 1);

        // Latency 16 single read: done 18 cycles after the IDLE sample
        core_req[3] = 1'b1; core_addr[3] = 32'h70;
        step();
        chk("t6_core_gnt", core_gnt[3], 1'b1);
        core_req[3] = 1'b0;
        repeat (16) step();
        chk("t6_done_c17", core_done[3], 1'b0);
        chk("t6_busy_c17", busy[3], 1'b1);
        step();
        chk("t6_done_c18", core_done[3], 1'b1);
        chk("t6_core_rdata", core_rdata[3], 32'hC0DE0070);
        step();
        chk("t6_idle", busy[3], 1'b0);
        chk("t6_en_count", en_cnt[3], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
